// File: rtl/sort_pipe_pkg.sv
// Shared constants and helpers for the odd-even transposition sorter.
package sort_pipe_pkg;

   localparam int SORT_WIDTH_DEF = 8;
   localparam int SORT_N_DEF     = 4;

   // Width of an element's source-index tag.
   function automatic int sort_idxw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Even layers pair (0,1),(2,3)...; odd layers pair (1,2),(3,4)...
   function automatic logic sort_odd_layer(input int s);
      return s[0];
   endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Single compare-exchange cell; lo/hi are the ordered pair for the requested direction.
// With SORT_PIPE_INDEX_EN defined, a source-index tag follows each element.
module sort_cmp_swap import sort_pipe_pkg::*; #(
   parameter int WIDTH  = SORT_WIDTH_DEF,
   parameter bit SIGNED = 1'b0
`ifdef SORT_PIPE_INDEX_EN
  ,parameter int IDXW   = 1
`endif
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             desc,
`ifdef SORT_PIPE_INDEX_EN
   input  logic [IDXW-1:0]  ta,
   input  logic [IDXW-1:0]  tb,
   output logic [IDXW-1:0]  tlo,
   output logic [IDXW-1:0]  thi,
`endif
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   logic gt, lt, swap;

   if (SIGNED) begin : g_s
      assign gt = $signed(a) > $signed(b);
      assign lt = $signed(a) < $signed(b);
   end else begin : g_u
      assign gt = a > b;
      assign lt = a < b;
   end

   // Strict compares keep equal elements in place, which makes the sort stable.
   assign swap = desc ? lt : gt;
   assign lo   = swap ? b : a;
   assign hi   = swap ? a : b;
`ifdef SORT_PIPE_INDEX_EN
   assign tlo  = swap ? tb : ta;
   assign thi  = swap ? ta : tb;
`endif

endmodule

// File: rtl/sort_pipe_oet.sv
// Fully pipelined N-element odd-even transposition sorter, one register stage per layer,
// with a global stall. SORT_PIPE_INDEX_EN adds out_idx (source index per output slot).
module sort_pipe_oet import sort_pipe_pkg::*; #(
   parameter int WIDTH  = SORT_WIDTH_DEF,
   parameter int N      = SORT_N_DEF,
   parameter bit SIGNED = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic               in_desc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*WIDTH-1:0] out_data,
   output logic               out_desc
`ifdef SORT_PIPE_INDEX_EN
  ,output logic [N*sort_idxw(N)-1:0] out_idx
`endif
);

   typedef logic [N-1:0][WIDTH-1:0] vec_t;

   vec_t         data_q [N];
   vec_t         data_d [N];
   logic [N-1:0] vld_pipe;
   logic [N-1:0] desc_q;
   logic         advance;

   assign advance  = out_ready | ~vld_pipe[N-1];
   assign in_ready = advance;

`ifdef SORT_PIPE_INDEX_EN
   localparam int IDXW = sort_idxw(N);
   typedef logic [N-1:0][IDXW-1:0] tag_t;

   tag_t idx_q [N];
   tag_t idx_d [N];
   tag_t idx_in;

   for (genvar i = 0; i < N; i++) begin : g_tag0
      assign idx_in[i] = IDXW'(i);
   end
`endif

   for (genvar s = 0; s < N; s++) begin : g_stage
      localparam int OFS = sort_odd_layer(s) ? 1 : 0;
      vec_t src, nxt;
      logic dsc;
`ifdef SORT_PIPE_INDEX_EN
      tag_t tsrc, tnxt;
`endif

      if (s == 0) begin : g_head
         assign src = in_data;
         assign dsc = in_desc;
`ifdef SORT_PIPE_INDEX_EN
         assign tsrc = idx_in;
`endif
      end else begin : g_body
         assign src = data_q[s-1];
         assign dsc = desc_q[s-1];
`ifdef SORT_PIPE_INDEX_EN
         assign tsrc = idx_q[s-1];
`endif
      end

      // Odd layers leave element 0 alone; the last pair slot covers element N-1.
      if (OFS == 1) begin : g_edge
         assign nxt[0] = src[0];
`ifdef SORT_PIPE_INDEX_EN
         assign tnxt[0] = tsrc[0];
`endif
      end

      for (genvar p = 0; p < N/2; p++) begin : g_pair
         localparam int L = 2*p + OFS;
         if (L + 1 < N) begin : g_cs
            sort_cmp_swap #(
               .WIDTH (WIDTH),
               .SIGNED(SIGNED)
`ifdef SORT_PIPE_INDEX_EN
              ,.IDXW  (IDXW)
`endif
            ) u_cs (
               .a   (src[L]),
               .b   (src[L+1]),
               .desc(dsc),
`ifdef SORT_PIPE_INDEX_EN
               .ta  (tsrc[L]),
               .tb  (tsrc[L+1]),
               .tlo (tnxt[L]),
               .thi (tnxt[L+1]),
`endif
               .lo  (nxt[L]),
               .hi  (nxt[L+1])
            );
         end else begin : g_pass
            assign nxt[L] = src[L];
`ifdef SORT_PIPE_INDEX_EN
            assign tnxt[L] = tsrc[L];
`endif
         end
      end

      assign data_d[s] = nxt;
`ifdef SORT_PIPE_INDEX_EN
      assign idx_d[s] = tnxt;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         desc_q   <= '0;
         for (int s = 0; s < N; s++) data_q[s] <= '0;
      end else if (advance) begin
         vld_pipe <= {vld_pipe[N-2:0], in_valid};
         desc_q   <= {desc_q[N-2:0], in_desc};
         for (int s = 0; s < N; s++) data_q[s] <= data_d[s];
      end
   end

`ifdef SORT_PIPE_INDEX_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < N; s++) idx_q[s] <= '0;
      end else if (advance) begin
         for (int s = 0; s < N; s++) idx_q[s] <= idx_d[s];
      end
   end

   assign out_idx = idx_q[N-1];
`endif

   assign out_valid = vld_pipe[N-1];
   assign out_data  = data_q[N-1];
   assign out_desc  = desc_q[N-1];

endmodule

// File: doc/sort_pipe_oet.md
Name: sort_pipe_oet

Overview:
Parametrised, fully pipelined sorter for N unsigned or signed WIDTH-bit values.
- Built as an odd-even transposition network of compare-exchange layers, one register stage per layer.
- Accepts one N-vector per cycle under a valid/ready handshake; outputs the sorted vector N cycles later.
- Adds runtime ascending/descending mode per vector and full backpressure support.
- Sits in the datapath as the general-width, general-count sorting stage used by the lab designs.

Parameters:
- WIDTH, 8, bits per element (≥1).
- N, 4, element count; even, 2..16.
- SIGNED, 0, 1 = compare as two's complement, 0 = unsigned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- in_valid  in  1  input vector present.
- in_ready  out  1  sorter can accept this cycle.
- in_data  in  N*WIDTH  element i at bits [i*WIDTH +: WIDTH].
- in_desc  in  1  0 = ascending (element 0 smallest), 1 = descending.
- out_valid  out  1  sorted vector present.
- out_ready  in  1  downstream accepts.
- out_data  out  N*WIDTH  sorted vector, same packing as in_data.
- out_desc  out  1  mode that travelled with this vector.

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Pipeline structure: N stages, indexed s = 0..N-1. Each stage holds valid_s, data_s and desc_s.
- Stage s applies compare layer s to the previous stage's contents. Stage 0 takes in_data.
  - s even: pairs (0,1),(2,3),…
  - s odd: pairs (1,2),(3,4),…; elements 0 and N-1 pass through unchanged.
- Compare-exchange for pair (lo,hi):
  - Ascending: swap iff a[lo] > a[hi].
  - Descending: swap iff a[lo] < a[hi].
  - Equal values never swap.
  - Comparison is signed when SIGNED=1.
  - No width growth; elements are moved, never modified.
- Global stall:
  - advance = out_ready | ~valid_{N-1}.
  - in_ready = advance (combinational).
  - When advance=0, every stage holds its contents.
  - When advance=1, all stages shift one place. valid_0 <= in_valid.
- Latency: vector accepted at edge k (in_valid & in_ready) is on out_data with out_valid=1 after edge k+N-1, with no stalls. Stalls add cycles one-for-one.
- Throughput: 1 vector/cycle while out_ready=1.
- Output stability: out_data and out_desc are stage N-1 registers, held stable while out_valid & ~out_ready.
- Bubbles: in_valid=0 while advancing inserts a bubble. Bubbles propagate and never produce out_valid.
- Simultaneous events: with the pipeline full, out_ready=1 and in_valid=1 in the same cycle → output retires and input is accepted in that cycle.
- Reset (rst=1 at an edge):
  - All valid_s = 0, all data_s = 0, all desc_s = 0.
  - Hence out_valid=0, out_data=0, out_desc=0.
  - in_ready=1 in the cycle after reset.
  - In-flight vectors are discarded, including mid-stall.
  - in_valid is ignored during reset.
- Mode: in_desc is sampled with the vector. Mixed modes may be in flight simultaneously.

Optional Feature:
- Macro: SORT_PIPE_INDEX_EN.
- Defined:
  - Adds port out_idx, out, N*IDXW, where IDXW = $clog2(N).
  - Each element carries its original input position as a tag, swapped together with the data.
  - out_idx slot i gives the source index of out_data slot i.
  - Tags reset to 0.
  - Because equal values never swap, the sort is stable by index.
- Undefined: no tag registers and no out_idx port; all other behaviour is identical.

Decomposition:
- Package sort_pipe_pkg:
  - Function/localparam for IDXW.
  - Helper function computing pair parity per stage.
  - Default WIDTH/N constants.
- Sub-module sort_cmp_swap:
  - One compare-exchange cell: inputs a, b, desc (plus tags when the optional feature is enabled); outputs lo, hi.
  - Parametrised by WIDTH and SIGNED; purely combinational.
  - Instantiated N/2 or N/2-1 times per stage by generate loops.

Test Plan:
- Basic ascending: N=4, WIDTH=8, in_data elements {7,3,9,1}, desc=0, out_ready=1 → after 4 edges out_data elements {1,3,7,9}, out_valid=1 for exactly 1 cycle.
- Descending and mode interleave: back-to-back {7,3,9,1} desc=1 then {7,3,9,1} desc=0 → consecutive outputs {9,7,3,1} (out_desc=1), then {1,3,7,9} (out_desc=0).
- Backpressure: stream 6 vectors; hold out_ready=0 for 3 cycles when the first reaches the output → in_ready=0 those cycles, out_data stable, all 6 vectors out in order, none lost or duplicated.
- Signed and duplicates: SIGNED=1, {0x80,0x7F,0x00,0x80} ascending → {0x80,0x80,0x00,0x7F}. With SORT_PIPE_INDEX_EN defined → out_idx {0,3,2,1} (stable).
- Worst case, N=8: reversed input {8,7,6,5,4,3,2,1} ascending → {1..8} after 8 edges. All-equal {5×8} → unchanged, idx {0..7}.
- Reset mid-flight: accept 2 vectors, assert rst 1 cycle at edge k+1 → out_valid stays 0 thereafter, out_data=0, in_ready=1 the next cycle, and a new vector sorts correctly.
